// File: rtl/four_bit_ripple_adder_pkg.sv
// ---------------------------------------------------------------------------
// four_bit_ripple_adder_pkg
// Purpose : shared width constant and nibble type for the 4-bit ripple adder
//           slice (package, interface, full_adder leaf, top).
// Ports   : none (package).
// Config  : FOUR_BIT_RIPPLE_ADDER_OVF_EN is honoured by the interface and top.
// ---------------------------------------------------------------------------
package four_bit_ripple_adder_pkg;

  localparam int ADDER_WIDTH = 4;

  typedef logic [ADDER_WIDTH-1:0] nibble_t;

endpackage : four_bit_ripple_adder_pkg

// File: rtl/four_bit_ripple_adder_if.sv
// ---------------------------------------------------------------------------
// four_bit_ripple_adder_if
// Purpose : bundles the adder operands and results.
// Signals : a, b            operands (unsigned nibbles)
//           sum, finalcarry combinational result
//           sum_q,
//           finalcarry_q    result registered one clock
//           ovf, ovf_q      signed overflow (only with FOUR_BIT_RIPPLE_ADDER_OVF_EN)
// Modports: master drives operands and observes results; slave is the adder.
// ---------------------------------------------------------------------------
interface four_bit_ripple_adder_if;
  import four_bit_ripple_adder_pkg::*;

  nibble_t a;
  nibble_t b;
  nibble_t sum;
  logic    finalcarry;
  nibble_t sum_q;
  logic    finalcarry_q;
`ifdef FOUR_BIT_RIPPLE_ADDER_OVF_EN
  logic    ovf;
  logic    ovf_q;
`endif

`ifdef FOUR_BIT_RIPPLE_ADDER_OVF_EN
  modport master (output a, b, input sum, finalcarry, sum_q, finalcarry_q, ovf, ovf_q);
  modport slave  (input a, b, output sum, finalcarry, sum_q, finalcarry_q, ovf, ovf_q);
`else
  modport master (output a, b, input sum, finalcarry, sum_q, finalcarry_q);
  modport slave  (input a, b, output sum, finalcarry, sum_q, finalcarry_q);
`endif

endinterface : four_bit_ripple_adder_if

// File: rtl/four_bit_ripple_adder_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Purpose : one-bit full adder cell, chained by four_bit_ripple_adder.
// Ports   : a, b, cin (in)  operand bits and carry in
//           sum, cout (out) sum bit and carry out
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign sum    = w_prop ^ cin;
  // generate when both bits set, otherwise propagate the incoming carry
  assign cout   = (a & b) | (cin & w_prop);

endmodule : full_adder

// File: rtl/four_bit_ripple_adder.sv
// ---------------------------------------------------------------------------
// four_bit_ripple_adder
// Purpose : unsigned 4-bit ripple-carry adder, carry-in 0. Combinational
//           result for datapath consumers plus a one-cycle registered copy.
// Ports   : clk    (in)  rising-edge clock for the output register
//           rst_n  (in)  asynchronous active-low reset of the output register
//           bus    (slave modport of four_bit_ripple_adder_if):
//                  a, b -> sum, finalcarry, sum_q, finalcarry_q [, ovf, ovf_q]
// Params  : WIDTH   must be 4 (elaboration error otherwise)
//           REG_OUT 1 builds the output register, 0 ties registered outputs to 0
// Config  : FOUR_BIT_RIPPLE_ADDER_OVF_EN adds signed overflow ovf = c4 ^ c3
//           and its registered copy ovf_q.
// ---------------------------------------------------------------------------
module four_bit_ripple_adder
  import four_bit_ripple_adder_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  four_bit_ripple_adder_if.slave   bus
);

  if (WIDTH != ADDER_WIDTH) begin : g_bad_width
    $error("four_bit_ripple_adder: WIDTH must be 4");
  end

  logic [ADDER_WIDTH:0]   w_carry;
  logic [ADDER_WIDTH-1:0] w_sum;

  assign w_carry[0] = 1'b0;

  // Ripple chain: each cell's carry out feeds the next cell's carry in.
  for (genvar gi = 0; gi < ADDER_WIDTH; gi++) begin : g_fa
    full_adder u_fa (
      .a    (bus.a[gi]),
      .b    (bus.b[gi]),
      .cin  (w_carry[gi]),
      .sum  (w_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  assign bus.sum        = w_sum;
  assign bus.finalcarry = w_carry[ADDER_WIDTH];

`ifdef FOUR_BIT_RIPPLE_ADDER_OVF_EN
  logic w_ovf;
  // signed overflow: carry into the sign bit differs from carry out of it
  assign w_ovf   = w_carry[ADDER_WIDTH] ^ w_carry[ADDER_WIDTH-1];
  assign bus.ovf = w_ovf;
`endif

  if (REG_OUT) begin : g_reg_out
    nibble_t r_sum_q;
    logic    r_finalcarry_q;
`ifdef FOUR_BIT_RIPPLE_ADDER_OVF_EN
    logic    r_ovf_q;

    // Output register: one-cycle copy of the result, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum_q        <= 4'h0;
        r_finalcarry_q <= 1'b0;
        r_ovf_q        <= 1'b0;
      end else begin
        r_sum_q        <= w_sum;
        r_finalcarry_q <= w_carry[ADDER_WIDTH];
        r_ovf_q        <= w_ovf;
      end
    end

    assign bus.ovf_q = r_ovf_q;
`else
    // Output register: one-cycle copy of the result, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum_q        <= 4'h0;
        r_finalcarry_q <= 1'b0;
      end else begin
        r_sum_q        <= w_sum;
        r_finalcarry_q <= w_carry[ADDER_WIDTH];
      end
    end
`endif
    assign bus.sum_q        = r_sum_q;
    assign bus.finalcarry_q = r_finalcarry_q;
  end else begin : g_no_reg_out
    assign bus.sum_q        = 4'h0;
    assign bus.finalcarry_q = 1'b0;
`ifdef FOUR_BIT_RIPPLE_ADDER_OVF_EN
    assign bus.ovf_q        = 1'b0;
`endif
  end

endmodule : four_bit_ripple_adder

// File: tb/tb_four_bit_ripple_adder.sv
// ---------------------------------------------------------------------------
// tb_four_bit_ripple_adder
// Purpose : self-checking bench for four_bit_ripple_adder. Expected values
//           come from integer arithmetic on the operands.
// Config  : FOUR_BIT_RIPPLE_ADDER_OVF_EN enables the overflow checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_four_bit_ripple_adder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  four_bit_ripple_adder_if u_if ();

  four_bit_ripple_adder #(
    .WIDTH   (4),
    .REG_OUT (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference: unsigned 5-bit result of a + b
  function automatic int ref_total(input int x, input int y);
    return x + y;
  endfunction

  // reference: two's-complement overflow of the 4-bit signed sum
  function automatic int ref_ovf(input int x, input int y);
    int sx;
    int sy;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    return ((sx + sy) > 7 || (sx + sy) < -8) ? 1 : 0;
  endfunction

  // apply operands away from the edge, check combinational now and registered after next edge
  task automatic apply_and_check(input int x, input int y, input string tag);
    int t;
    @(negedge clk);
    u_if.a = 4'(x);
    u_if.b = 4'(y);
    #1;
    t = ref_total(x, y);
    check_val({tag, "_sum"}, {28'h0, u_if.sum}, t % 16);
    check_val({tag, "_carry"}, {31'h0, u_if.finalcarry}, t / 16);
`ifdef FOUR_BIT_RIPPLE_ADDER_OVF_EN
    check_val({tag, "_ovf"}, {31'h0, u_if.ovf}, ref_ovf(x, y));
`endif
    @(posedge clk);
    #1;
    check_val({tag, "_sum_q"}, {28'h0, u_if.sum_q}, t % 16);
    check_val({tag, "_carry_q"}, {31'h0, u_if.finalcarry_q}, t / 16);
`ifdef FOUR_BIT_RIPPLE_ADDER_OVF_EN
    check_val({tag, "_ovf_q"}, {31'h0, u_if.ovf_q}, ref_ovf(x, y));
`endif
  endtask

  initial begin
    int x;
    int y;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    u_if.a   = 4'h3;
    u_if.b   = 4'h4;

    // reset state: registered outputs clear, combinational already valid
    #2;
    check_val("rst_sum_q", {28'h0, u_if.sum_q}, 32'd0);
    check_val("rst_carry_q", {31'h0, u_if.finalcarry_q}, 32'd0);
    check_val("rst_comb_sum", {28'h0, u_if.sum}, 32'd7);
    @(posedge clk);
    #1;
    check_val("rst_hold_sum_q", {28'h0, u_if.sum_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed corner cases
    apply_and_check(15, 1, "ripple_f_1");
    apply_and_check(5, 10, "nocarry_5_a");
    apply_and_check(15, 15, "wrap_f_f");
    apply_and_check(0, 0, "zero");
    apply_and_check(7, 1, "ovf_7_1");
    apply_and_check(8, 8, "ovf_8_8");

    // exhaustive sweep, one pair per clock
    for (int i = 0; i < 256; i++) begin
      apply_and_check(i / 16, i % 16, "exh");
    end

    // randomized pairs
    for (int i = 0; i < 64; i++) begin
      x = int'($urandom_range(15, 0));
      y = int'($urandom_range(15, 0));
      apply_and_check(x, y, "rnd");
    end

    // mid-operation reset between edges
    apply_and_check(15, 15, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_sum_q", {28'h0, u_if.sum_q}, 32'd0);
    check_val("midrst_carry_q", {31'h0, u_if.finalcarry_q}, 32'd0);
    check_val("midrst_sum", {28'h0, u_if.sum}, 32'd14);
    check_val("midrst_carry", {31'h0, u_if.finalcarry}, 32'd1);
    u_if.a = 4'h9;
    u_if.b = 4'h8;
    @(posedge clk);
    #1;
    check_val("inrst_sum_q", {28'h0, u_if.sum_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rel_sum_q_before_edge", {28'h0, u_if.sum_q}, 32'd0);
    @(posedge clk);
    #1;
    check_val("rel_sum_q", {28'h0, u_if.sum_q}, 32'd1);
    check_val("rel_carry_q", {31'h0, u_if.finalcarry_q}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_four_bit_ripple_adder
